// File: rtl/nios_debug_scan_pkg.sv
// Shared types and constants for the Nios II debug virtual-JTAG scan master.
package nios_debug_scan_pkg;

    localparam int DATA_W_DEF = 38;
    localparam int IR_W_DEF   = 2;

    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RTI,
        ST_RESP
    } scan_state_e;

endpackage

// File: rtl/nios_debug_scan_tck_gen.sv
// Test-clock divider: tck is low for the first TCK_HALF clk cycles of each
// period and high for the rest; the counter parks at zero while disabled.
module nios_debug_scan_tck_gen #(
    parameter int TCK_HALF = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic tck_o,
    output logic tck_rise_o,
    output logic period_end_o
);

    localparam int CW = $clog2(2 * TCK_HALF);
    localparam logic [CW-1:0] HALF = CW'(TCK_HALF);
    localparam logic [CW-1:0] LAST = CW'(2 * TCK_HALF - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || !en_i) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tck_o        = en_i && (cnt_q >= HALF);
    assign tck_rise_o   = en_i && (cnt_q == HALF);
    assign period_end_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/nios_system_debug_scan_master.sv
// Drives one update-IR / capture-DR / shift-DR / update-DR / run-test-idle
// sequence into the debug module's vji_* pins per accepted command.
module nios_system_debug_scan_master
    import nios_debug_scan_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int IR_W       = IR_W_DEF,
    parameter int TCK_HALF   = 2,
    parameter int RTI_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [IR_W-1:0]   cmd_ir,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [IR_W-1:0]   rsp_ir,
    output logic              vji_tck,
    output logic              vji_tdi,
    input  logic              vji_tdo,
    output logic [IR_W-1:0]   vji_ir_in,
    input  logic [IR_W-1:0]   vji_ir_out,
    output logic              vji_uir,
    output logic              vji_cdr,
    output logic              vji_sdr,
    output logic              vji_udr,
    output logic              vji_rti,
    output scan_state_e       dbg_state
);

    // Valid/ready: a transfer happens on the clk edge where valid and ready
    // are both high; valid holds its payload until then, ready never waits on valid.

    localparam int PER_MAX = (DATA_W > RTI_CYCLES) ? DATA_W : RTI_CYCLES;
    localparam int PER_W   = $clog2(PER_MAX + 1);
    localparam logic [PER_W-1:0] SDR_LAST = PER_W'(DATA_W - 1);
    localparam logic [PER_W-1:0] RTI_LAST = PER_W'(RTI_CYCLES - 1);

    scan_state_e       state_q;
    logic [PER_W-1:0]  per_q;
    logic [IR_W-1:0]   ir_q;
    logic [IR_W-1:0]   rsp_ir_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] cap_q;
    logic [DATA_W-1:0] tx_shift_d;
    logic [DATA_W-1:0] cap_shift_d;
    logic              busy;
    logic              tck;
    logic              tck_rise;
    logic              period_end;

    assign busy = (state_q != ST_IDLE) && (state_q != ST_RESP);

    nios_debug_scan_tck_gen #(
        .TCK_HALF(TCK_HALF)
    ) u_tck_gen (
        .clk          (clk),
        .reset        (reset),
        .en_i         (busy),
        .tck_o        (tck),
        .tck_rise_o   (tck_rise),
        .period_end_o (period_end)
    );

    always_comb begin
        tx_shift_d               = tx_q >> 1;
        cap_shift_d              = cap_q >> 1;
        cap_shift_d[DATA_W-1]    = vji_tdo;
    end

    // tdo is captured at the rising point, but tdi only advances at the
    // period boundary so it never moves while tck is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            per_q    <= '0;
            ir_q     <= '0;
            rsp_ir_q <= '0;
            tx_q     <= '0;
            cap_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state_q <= ST_UIR;
                        ir_q    <= cmd_ir;
                        tx_q    <= cmd_data;
                    end
                end
                ST_UIR: begin
                    if (tck_rise) rsp_ir_q <= vji_ir_out;
                    if (period_end) state_q <= ST_CDR;
                end
                ST_CDR: begin
                    if (period_end) begin
                        state_q <= ST_SDR;
                        per_q   <= '0;
                    end
                end
                ST_SDR: begin
                    if (tck_rise) cap_q <= cap_shift_d;
                    if (period_end) begin
                        tx_q <= tx_shift_d;
                        if (per_q == SDR_LAST) begin
                            state_q <= ST_UDR;
                            per_q   <= '0;
                        end else begin
                            per_q <= per_q + PER_W'(1);
                        end
                    end
                end
                ST_UDR: begin
                    if (period_end) state_q <= ST_RTI;
                end
                ST_RTI: begin
                    if (period_end) begin
                        if (per_q == RTI_LAST) begin
                            state_q <= ST_RESP;
                            per_q   <= '0;
                        end else begin
                            per_q <= per_q + PER_W'(1);
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = cap_q;
    assign rsp_ir    = rsp_ir_q;
    assign vji_tck   = tck;
    assign vji_tdi   = tx_q[0];
    assign vji_ir_in = ir_q;
    assign vji_uir   = (state_q == ST_UIR);
    assign vji_cdr   = (state_q == ST_CDR);
    assign vji_sdr   = (state_q == ST_SDR);
    assign vji_udr   = (state_q == ST_UDR);
    assign vji_rti   = (state_q == ST_RTI);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_nios_system_debug_scan_master.sv
// Self-checking bench: default instance against a tck-side debug-module model,
// plus a TCK_HALF=1 instance and a DATA_W=1/RTI_CYCLES=3 instance.
module tb_nios_system_debug_scan_master;
  import nios_debug_scan_pkg::*;

  localparam int W = 38;

  int n_tests = 0;
  int n_fail  = 0;

  // clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: defaults
  logic rst_a = 1'b1, cmd_valid_a = 1'b0, rsp_ready_a = 1'b0;
  logic [1:0] cmd_ir_a = '0, ir_out_a = '0;
  logic [W-1:0] cmd_data_a = '0;
  logic cmd_ready_a, rsp_valid_a, tck_a, tdi_a, tdo_a;
  logic uir_a, cdr_a, sdr_a, udr_a, rti_a;
  logic [W-1:0] rsp_data_a;
  logic [1:0] rsp_ir_a, ir_in_a;
  scan_state_e st_a;

  nios_system_debug_scan_master u_dut_a (
    .clk(clk), .reset(rst_a), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_ir(cmd_ir_a), .cmd_data(cmd_data_a), .rsp_valid(rsp_valid_a),
    .rsp_ready(rsp_ready_a), .rsp_data(rsp_data_a), .rsp_ir(rsp_ir_a),
    .vji_tck(tck_a), .vji_tdi(tdi_a), .vji_tdo(tdo_a), .vji_ir_in(ir_in_a),
    .vji_ir_out(ir_out_a), .vji_uir(uir_a), .vji_cdr(cdr_a), .vji_sdr(sdr_a),
    .vji_udr(udr_a), .vji_rti(rti_a), .dbg_state(st_a)
  );

  // instance B: TCK_HALF=1
  logic rst_b = 1'b1, cmd_valid_b = 1'b0, rsp_ready_b = 1'b0, tdo_b = 1'b0;
  logic [1:0] cmd_ir_b = '0, ir_out_b = '0;
  logic [W-1:0] cmd_data_b = '0;
  logic cmd_ready_b, rsp_valid_b, tck_b, tdi_b;
  logic uir_b, cdr_b, sdr_b, udr_b, rti_b;
  logic [W-1:0] rsp_data_b;
  logic [1:0] rsp_ir_b, ir_in_b;
  scan_state_e st_b;

  nios_system_debug_scan_master #(.TCK_HALF(1)) u_dut_b (
    .clk(clk), .reset(rst_b), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_ir(cmd_ir_b), .cmd_data(cmd_data_b), .rsp_valid(rsp_valid_b),
    .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b), .rsp_ir(rsp_ir_b),
    .vji_tck(tck_b), .vji_tdi(tdi_b), .vji_tdo(tdo_b), .vji_ir_in(ir_in_b),
    .vji_ir_out(ir_out_b), .vji_uir(uir_b), .vji_cdr(cdr_b), .vji_sdr(sdr_b),
    .vji_udr(udr_b), .vji_rti(rti_b), .dbg_state(st_b)
  );

  // instance C: DATA_W=1, RTI_CYCLES=3
  logic rst_c = 1'b1, cmd_valid_c = 1'b0, rsp_ready_c = 1'b0, tdo_c = 1'b0;
  logic [1:0] cmd_ir_c = '0, ir_out_c = 2'b11;
  logic [0:0] cmd_data_c = '0;
  logic cmd_ready_c, rsp_valid_c, tck_c, tdi_c;
  logic uir_c, cdr_c, sdr_c, udr_c, rti_c;
  logic [0:0] rsp_data_c;
  logic [1:0] rsp_ir_c, ir_in_c;
  scan_state_e st_c;

  nios_system_debug_scan_master #(.DATA_W(1), .RTI_CYCLES(3)) u_dut_c (
    .clk(clk), .reset(rst_c), .cmd_valid(cmd_valid_c), .cmd_ready(cmd_ready_c),
    .cmd_ir(cmd_ir_c), .cmd_data(cmd_data_c), .rsp_valid(rsp_valid_c),
    .rsp_ready(rsp_ready_c), .rsp_data(rsp_data_c), .rsp_ir(rsp_ir_c),
    .vji_tck(tck_c), .vji_tdi(tdi_c), .vji_tdo(tdo_c), .vji_ir_in(ir_in_c),
    .vji_ir_out(ir_out_c), .vji_uir(uir_c), .vji_cdr(cdr_c), .vji_sdr(sdr_c),
    .vji_udr(udr_c), .vji_rti(rti_c), .dbg_state(st_c)
  );

  // tck-side debug-module model for A: tdi taken on tck rise, tdo moves on tck fall
  logic [W-1:0] model_sr = '0;
  logic [W-1:0] model_at_udr = '0;
  logic pend = 1'b0, pend_bit = 1'b0;
  int rise_cnt = 0;
  assign tdo_a = model_sr[0];

  always @(posedge tck_a) begin
    rise_cnt = rise_cnt + 1;
    if (sdr_a) begin
      pend = 1'b1;
      pend_bit = tdi_a;
    end
    if (udr_a) model_at_udr = model_sr;
  end

  always @(negedge tck_a) begin
    if (pend) begin
      model_sr = {pend_bit, model_sr[W-1:1]};
      pend = 1'b0;
    end
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] next_exp = '0;

  // driver tasks
  task automatic preload_a(input logic [W-1:0] v);
    model_sr = v;
    pend = 1'b0;
    next_exp = v;
  endtask

  task automatic send_a(input logic [1:0] ir, input logic [W-1:0] data);
    cmd_ir_a = ir;
    cmd_data_a = data;
    cmd_valid_a = 1'b1;
    for (int i = 0; i < 400 && !cmd_ready_a; i++) @(negedge clk);
    n_tests++;
    if (cmd_ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL send_a_ready: got %b, want 1", cmd_ready_a);
    end
    exp_q.push_back(next_exp);
    next_exp = data;
    @(negedge clk);
    cmd_valid_a = 1'b0;
  endtask

  // called at the negedge of cycle 1 (first UIR cycle); returns cycle number of rsp_valid
  task automatic wait_rsp_a(output int cyc);
    cyc = 1;
    while (!rsp_valid_a && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_rsp_a(input string name);
    logic [W-1:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got response %h, want none queued", name, rsp_data_a);
    end else begin
      e = exp_q.pop_front();
      if (rsp_data_a !== e) begin
        n_fail++;
        $display("FAIL %s: got %h, want %h", name, rsp_data_a, e);
      end
    end
  endtask

  task automatic consume_a();
    rsp_ready_a = 1'b1;
    @(negedge clk);
    rsp_ready_a = 1'b0;
  endtask

  task automatic test_reset();
    int hi;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({cmd_ready_a, rsp_valid_a, tck_a, tdi_a, uir_a, cdr_a, sdr_a, udr_a, rti_a} !== 9'b1_0000_0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, want 100000000", {cmd_ready_a, rsp_valid_a, tck_a, tdi_a, uir_a, cdr_a, sdr_a, udr_a, rti_a});
    end
    n_tests++;
    if ({rsp_data_a, rsp_ir_a, ir_in_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h/%h, want 0", rsp_data_a, rsp_ir_a, ir_in_a);
    end
    n_tests++;
    if (st_a !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d, want %0d", st_a, ST_IDLE);
    end
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tck_a !== 1'b0 || cmd_ready_a !== 1'b1) hi++;
    end
    n_tests++;
    if (hi != 0) begin
      n_fail++;
      $display("FAIL reset_tck_static: got %0d bad cycles, want 0", hi);
    end
  endtask

  task automatic test_scan_exchange();
    int cyc;
    ir_out_a = 2'b10;
    preload_a(38'h2A_DEAD_BEEF);
    rise_cnt = 0;
    send_a(IR_BREAK, 38'h15_1234_5678);
    n_tests++;
    if (uir_a !== 1'b1 || ir_in_a !== IR_BREAK) begin
      n_fail++;
      $display("FAIL scan_uir_start: got uir=%b ir_in=%0d, want uir=1 ir_in=2", uir_a, ir_in_a);
    end
    wait_rsp_a(cyc);
    n_tests++;
    if (cyc != 169) begin
      n_fail++;
      $display("FAIL scan_latency: got %0d, want 169", cyc);
    end
    check_rsp_a("scan_rsp_data");
    n_tests++;
    if (rsp_ir_a !== 2'b10) begin
      n_fail++;
      $display("FAIL scan_rsp_ir: got %b, want 10", rsp_ir_a);
    end
    n_tests++;
    if (model_at_udr !== 38'h15_1234_5678) begin
      n_fail++;
      $display("FAIL scan_model_udr: got %h, want 1512345678", model_at_udr);
    end
    n_tests++;
    if (rise_cnt != 42) begin
      n_fail++;
      $display("FAIL scan_tck_rises: got %0d, want 42", rise_cnt);
    end
    consume_a();
    n_tests++;
    if (rsp_valid_a !== 1'b0 || cmd_ready_a !== 1'b1 || ir_in_a !== IR_BREAK) begin
      n_fail++;
      $display("FAIL scan_release: got valid=%b ready=%b ir_in=%0d, want 0 1 2", rsp_valid_a, cmd_ready_a, ir_in_a);
    end
  endtask

  task automatic test_back_pressure();
    int cyc, bad;
    logic [W-1:0] d1, d2, snap;
    d1 = W'({$urandom(), $urandom()});
    d2 = W'({$urandom(), $urandom()});
    ir_out_a = 2'b01;
    send_a(IR_OCIMEM, d1);
    cmd_ir_a = IR_TRACEMEM;
    cmd_data_a = d2;
    cmd_valid_a = 1'b1;
    wait_rsp_a(cyc);
    n_tests++;
    if (cyc != 169) begin
      n_fail++;
      $display("FAIL bp_latency1: got %0d, want 169", cyc);
    end
    snap = rsp_data_a;
    check_rsp_a("bp_rsp1");
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_data_a !== snap || cmd_ready_a !== 1'b0 || rsp_valid_a !== 1'b1 || rsp_ir_a !== 2'b01) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: got %0d unstable cycles, want 0", bad);
    end
    rsp_ready_a = 1'b1;
    @(negedge clk);
    rsp_ready_a = 1'b0;
    n_tests++;
    if (cmd_ready_a !== 1'b1 || rsp_valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_resp_exit: got ready=%b valid=%b, want 1 0", cmd_ready_a, rsp_valid_a);
    end
    exp_q.push_back(next_exp);
    next_exp = d2;
    @(negedge clk);
    cmd_valid_a = 1'b0;
    n_tests++;
    if (uir_a !== 1'b1 || ir_in_a !== IR_TRACEMEM) begin
      n_fail++;
      $display("FAIL bp_second_accept: got uir=%b ir_in=%0d, want 1 1", uir_a, ir_in_a);
    end
    wait_rsp_a(cyc);
    n_tests++;
    if (cyc != 169) begin
      n_fail++;
      $display("FAIL bp_latency2: got %0d, want 169", cyc);
    end
    check_rsp_a("bp_rsp2");
    consume_a();
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [W-1:0] d3, d4;
    d3 = W'({$urandom(), $urandom()});
    d4 = W'({$urandom(), $urandom()});
    rsp_ready_a = 1'b1;
    send_a(IR_TRACECTRL, d3);
    wait_rsp_a(cyc);
    check_rsp_a("b2b_rsp1");
    @(negedge clk);
    n_tests++;
    if (rsp_valid_a !== 1'b0 || cmd_ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_one_cycle_resp: got valid=%b ready=%b, want 0 1", rsp_valid_a, cmd_ready_a);
    end
    send_a(IR_OCIMEM, d4);
    wait_rsp_a(cyc);
    n_tests++;
    if (cyc != 169) begin
      n_fail++;
      $display("FAIL b2b_latency2: got %0d, want 169", cyc);
    end
    check_rsp_a("b2b_rsp2");
    @(negedge clk);
    rsp_ready_a = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    int n, guard, cyc, seen;
    logic prev;
    preload_a(38'h3_0F0F_0F0F);
    send_a(IR_BREAK, W'({$urandom(), $urandom()}));
    n = 0; guard = 0; prev = 1'b0;
    while (n < 20 && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (sdr_a && tck_a && !prev) n++;
      prev = tck_a;
    end
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    void'(exp_q.pop_back());
    n_tests++;
    if ({uir_a, cdr_a, sdr_a, udr_a, rti_a, rsp_valid_a, tck_a} !== 7'b0 || ir_in_a !== 2'b00 || cmd_ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_values: got flags=%b ir_in=%b ready=%b, want 0 0 1",
               {uir_a, cdr_a, sdr_a, udr_a, rti_a, rsp_valid_a, tck_a}, ir_in_a, cmd_ready_a);
    end
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid_a || !cmd_ready_a) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL midrst_no_rsp: got %0d busy cycles, want 0", seen);
    end
    preload_a(38'h0A_5A5A_5A5A);
    send_a(IR_TRACEMEM, W'({$urandom(), $urandom()}));
    wait_rsp_a(cyc);
    n_tests++;
    if (cyc != 169) begin
      n_fail++;
      $display("FAIL midrst_latency: got %0d, want 169", cyc);
    end
    check_rsp_a("midrst_rsp");
    consume_a();
  endtask

  task automatic test_flags();
    int cyc, n_uir, n_cdr, n_sdr, n_udr, n_rti, tdi_bad, multi;
    logic prev_tdi;
    cmd_data_b = W'({$urandom(), $urandom()});
    cmd_ir_b = IR_BREAK;
    cmd_valid_b = 1'b1;
    for (int i = 0; i < 10 && !cmd_ready_b; i++) @(negedge clk);
    @(negedge clk);
    cmd_valid_b = 1'b0;
    n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0; tdi_bad = 0; multi = 0;
    prev_tdi = tdi_b;
    cyc = 1;
    while (!rsp_valid_b && cyc < 1000) begin
      n_uir += int'(uir_b); n_cdr += int'(cdr_b); n_sdr += int'(sdr_b);
      n_udr += int'(udr_b); n_rti += int'(rti_b);
      if ($countones({uir_b, cdr_b, sdr_b, udr_b, rti_b}) != 1) multi++;
      if (tck_b && tdi_b !== prev_tdi) tdi_bad++;
      prev_tdi = tdi_b;
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (cyc != 85) begin
      n_fail++;
      $display("FAIL flags_latency: got %0d, want 85", cyc);
    end
    n_tests++;
    if (n_uir != 2 || n_cdr != 2 || n_udr != 2 || n_rti != 2) begin
      n_fail++;
      $display("FAIL flags_short: got uir=%0d cdr=%0d udr=%0d rti=%0d, want 2 each", n_uir, n_cdr, n_udr, n_rti);
    end
    n_tests++;
    if (n_sdr != 76) begin
      n_fail++;
      $display("FAIL flags_sdr: got %0d, want 76", n_sdr);
    end
    n_tests++;
    if (multi != 0 || tdi_bad != 0) begin
      n_fail++;
      $display("FAIL flags_onehot_tdi: got %0d non-onehot, %0d tdi moves, want 0 0", multi, tdi_bad);
    end
    n_tests++;
    if (rsp_data_b !== '0) begin
      n_fail++;
      $display("FAIL flags_rsp_zero: got %h, want 0", rsp_data_b);
    end
    rsp_ready_b = 1'b1;
    @(negedge clk);
    rsp_ready_b = 1'b0;
  endtask

  task automatic test_edge_params();
    int cyc, n_rti;
    for (int k = 0; k < 2; k++) begin
      tdo_c = (k == 0) ? 1'b1 : 1'b0;
      cmd_data_c = 1'($urandom_range(0, 1));
      cmd_valid_c = 1'b1;
      for (int i = 0; i < 10 && !cmd_ready_c; i++) @(negedge clk);
      @(negedge clk);
      cmd_valid_c = 1'b0;
      cyc = 1; n_rti = 0;
      while (!rsp_valid_c && cyc < 1000) begin
        n_rti += int'(rti_c);
        @(negedge clk);
        cyc++;
      end
      n_tests++;
      if (cyc != 29 || n_rti != 12) begin
        n_fail++;
        $display("FAIL edge_latency_%0d: got %0d/%0d, want 29/12", k, cyc, n_rti);
      end
      n_tests++;
      if (rsp_data_c[0] !== tdo_c || rsp_ir_c !== 2'b11) begin
        n_fail++;
        $display("FAIL edge_rsp_%0d: got %b/%b, want %b/11", k, rsp_data_c, rsp_ir_c, tdo_c);
      end
      rsp_ready_c = 1'b1;
      @(negedge clk);
      rsp_ready_c = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_scan_exchange();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid_shift();
    test_flags();
    test_edge_params();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
